// File: rtl/vx_wb_receiver_pkg.sv
// Shared sizing constants and the writeback beat format for the writeback receiver.
package vx_wb_receiver_pkg;

  localparam int NUM_THREADS  = 4;
  localparam int NUM_WARPS    = 4;
  localparam int NUM_REGS     = 32;
  localparam int NW_BITS      = $clog2(NUM_WARPS);
  localparam int NR_BITS      = $clog2(NUM_REGS);
  localparam int WB_RCV_DEPTH = 2;

  typedef struct packed {
    logic [NW_BITS-1:0]        wid;
    logic [31:0]               pc;
    logic [NUM_THREADS-1:0]    tmask;
    logic [NR_BITS-1:0]        rd;
    logic [NUM_THREADS*32-1:0] data;
    logic                      eop;
  } wb_beat_t;

  typedef logic [NUM_WARPS-1:0][NUM_REGS-1:0] sb_bitmap_t;

endpackage

// File: rtl/vx_wb_receiver_if.sv
// Writeback beat channel: valid/ready handshake plus the beat payload.
interface vx_wb_receiver_if;
  import vx_wb_receiver_pkg::*;

  logic                      valid;
  logic                      ready;
  logic [NW_BITS-1:0]        wid;
  logic [31:0]               pc;
  logic [NUM_THREADS-1:0]    tmask;
  logic [NR_BITS-1:0]        rd;
  logic [NUM_THREADS*32-1:0] data;
  logic                      eop;

  modport master (output valid, wid, pc, tmask, rd, data, eop, input ready);
  modport slave  (input valid, wid, pc, tmask, rd, data, eop, output ready);

endinterface

// File: rtl/vx_wb_receiver_skid.sv
// Two-entry skid FIFO whose ready is registered, so upstream never sees a
// combinational path from the register-file ready.
module vx_wb_receiver_skid
  import vx_wb_receiver_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     in_valid,
  output logic     in_ready,
  input  wb_beat_t in_beat,
  output logic     out_valid,
  output wb_beat_t out_beat,
  input  logic     out_ready,
  output logic     empty_next
);

  localparam int PTR_W = $clog2(WB_RCV_DEPTH);
  localparam int CNT_W = $clog2(WB_RCV_DEPTH + 1);

  wb_beat_t         mem [WB_RCV_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             push, pop;

  assign push       = in_valid && in_ready;
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign out_beat   = mem[rd_ptr];
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign empty_next = (count_next == '0);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      count    <= count_next;
      in_ready <= (count_next <= CNT_W'(WB_RCV_DEPTH - 1));
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: storage has no reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_beat;
  end

endmodule

// File: rtl/vx_wb_receiver.sv
// Writeback receiver: buffers beats, drives the register-file write port and
// keeps the per-warp register reservation scoreboard with release pulses.
module vx_wb_receiver
  import vx_wb_receiver_pkg::*;
#(
  parameter int CORE_ID = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  vx_wb_receiver_if.slave           wb,
  input  logic                      rsv_valid,
  input  logic [NW_BITS-1:0]        rsv_wid,
  input  logic [NR_BITS-1:0]        rsv_rd,
  input  logic [NW_BITS-1:0]        chk_wid,
  input  logic [NR_BITS-1:0]        chk_rs1,
  input  logic [NR_BITS-1:0]        chk_rs2,
  input  logic [NR_BITS-1:0]        chk_rs3,
  input  logic [NR_BITS-1:0]        chk_rd,
  output logic                      chk_busy,
  output logic [NUM_THREADS-1:0]    rf_wr_en,
  output logic [NW_BITS-1:0]        rf_wr_wid,
  output logic [NR_BITS-1:0]        rf_wr_rd,
  output logic [NUM_THREADS*32-1:0] rf_wr_data,
  input  logic                      rf_wr_ready,
  output logic                      rel_valid,
  output logic [NW_BITS-1:0]        rel_wid,
  output logic [NR_BITS-1:0]        rel_rd,
  output logic                      idle,
  output logic [31:0]               last_wb_value [NUM_REGS]
);

  wb_beat_t   in_beat, head;
  logic       head_valid, pop, clr, rsv_set, rsv_dup, fifo_empty_next;
  sb_bitmap_t bitmap_q, bitmap_d;
  logic       unused_pc;

  assign in_beat = '{wid: wb.wid, pc: wb.pc, tmask: wb.tmask, rd: wb.rd,
                     data: wb.data, eop: wb.eop};

  vx_wb_receiver_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (wb.valid),
    .in_ready   (wb.ready),
    .in_beat    (in_beat),
    .out_valid  (head_valid),
    .out_beat   (head),
    .out_ready  (rf_wr_ready),
    .empty_next (fifo_empty_next)
  );

  // Writes to x0 are suppressed but the beat still drains normally.
  assign pop        = head_valid && rf_wr_ready;
  assign rf_wr_en   = (head_valid && head.rd != '0) ? head.tmask : '0;
  assign rf_wr_wid  = head.wid;
  assign rf_wr_rd   = head.rd;
  assign rf_wr_data = head.data;
  assign unused_pc  = ^head.pc;

  assign clr     = pop && head.eop;
  assign rsv_set = rsv_valid && (rsv_rd != '0);
  assign rsv_dup = rsv_set && bitmap_q[rsv_wid][rsv_rd] &&
                   !(clr && head.wid == rsv_wid && head.rd == rsv_rd);

  // NOTE: bitmap_d gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    bitmap_d = bitmap_q;
    if (clr)     bitmap_d[head.wid][head.rd] = 1'b0;
    if (rsv_set) bitmap_d[rsv_wid][rsv_rd]   = 1'b1;
  end

  always_comb begin
    chk_busy = 1'b0;
    if (chk_rs1 != '0 && bitmap_q[chk_wid][chk_rs1]) chk_busy = 1'b1;
    if (chk_rs2 != '0 && bitmap_q[chk_wid][chk_rs2]) chk_busy = 1'b1;
    if (chk_rs3 != '0 && bitmap_q[chk_wid][chk_rs3]) chk_busy = 1'b1;
    if (chk_rd  != '0 && bitmap_q[chk_wid][chk_rd])  chk_busy = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitmap_q  <= '0;
      rel_valid <= 1'b0;
      rel_wid   <= '0;
      rel_rd    <= '0;
      idle      <= 1'b1;
    end else begin
      bitmap_q  <= bitmap_d;
      rel_valid <= clr;
      rel_wid   <= head.wid;
      rel_rd    <= head.rd;
      idle      <= (bitmap_d == '0) && fifo_empty_next;
    end
  end

  always_ff @(posedge clk) begin
    if (pop && head.rd != '0) last_wb_value[head.rd] <= head.data[31:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!rsv_dup)
        else $error("core%0d: wid=%0d rd=%0d reserved while already busy",
                    CORE_ID, rsv_wid, rsv_rd);
    end
  end

endmodule

// File: tb/tb_vx_wb_receiver.sv
// Directed bench for vx_wb_receiver: reset, latency, back-pressure, x0,
// reserve/release interplay and mid-traffic reset.
module tb_vx_wb_receiver;
  import vx_wb_receiver_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      rsv_valid;
  logic [NW_BITS-1:0]        rsv_wid;
  logic [NR_BITS-1:0]        rsv_rd;
  logic [NW_BITS-1:0]        chk_wid;
  logic [NR_BITS-1:0]        chk_rs1, chk_rs2, chk_rs3, chk_rd;
  logic                      chk_busy;
  logic [NUM_THREADS-1:0]    rf_wr_en;
  logic [NW_BITS-1:0]        rf_wr_wid;
  logic [NR_BITS-1:0]        rf_wr_rd;
  logic [NUM_THREADS*32-1:0] rf_wr_data;
  logic                      rf_wr_ready;
  logic                      rel_valid;
  logic [NW_BITS-1:0]        rel_wid;
  logic [NR_BITS-1:0]        rel_rd;
  logic                      idle;
  logic [31:0]               last_wb_value [NUM_REGS];

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [127:0] D0 = 128'h4444_0003_3333_0002_2222_0001_1111_0000;
  localparam logic [127:0] D1 = 128'hFFFF_FFFF_EEEE_EEEE_DDDD_DDDD_CCCC_CCCC;
  localparam logic [127:0] DA = 128'hA000_0003_A000_0002_A000_0001_A000_0000;
  localparam logic [127:0] DB = 128'hB000_0003_B000_0002_B000_0001_B000_0000;
  localparam logic [127:0] DC = 128'hC000_0003_C000_0002_C000_0001_C000_0000;
  localparam logic [127:0] D2 = 128'h0707_0707_0707_0707_0707_0707_0707_0707;
  localparam logic [127:0] D3 = 128'h0909_0001_0909_0002_0909_0003_0909_0004;

  vx_wb_receiver_if wb_if ();

  vx_wb_receiver #(.CORE_ID(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .wb            (wb_if),
    .rsv_valid     (rsv_valid),
    .rsv_wid       (rsv_wid),
    .rsv_rd        (rsv_rd),
    .chk_wid       (chk_wid),
    .chk_rs1       (chk_rs1),
    .chk_rs2       (chk_rs2),
    .chk_rs3       (chk_rs3),
    .chk_rd        (chk_rd),
    .chk_busy      (chk_busy),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_wid     (rf_wr_wid),
    .rf_wr_rd      (rf_wr_rd),
    .rf_wr_data    (rf_wr_data),
    .rf_wr_ready   (rf_wr_ready),
    .rel_valid     (rel_valid),
    .rel_wid       (rel_wid),
    .rel_rd        (rel_rd),
    .idle          (idle),
    .last_wb_value (last_wb_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [NW_BITS-1:0] wid, input logic [NR_BITS-1:0] rd,
                            input logic [NUM_THREADS-1:0] tmask, input logic [127:0] data,
                            input logic eop);
    wb_if.valid = 1'b1;
    wb_if.wid   = wid;
    wb_if.pc    = 32'h8000_0000 | 32'(rd);
    wb_if.tmask = tmask;
    wb_if.rd    = rd;
    wb_if.data  = data;
    wb_if.eop   = eop;
  endtask

  task automatic clear_beat();
    wb_if.valid = 1'b0;
  endtask

  task automatic reserve(input logic [NW_BITS-1:0] wid, input logic [NR_BITS-1:0] rd);
    rsv_valid = 1'b1;
    rsv_wid   = wid;
    rsv_rd    = rd;
    step();
    rsv_valid = 1'b0;
  endtask

  task automatic query(input logic [NW_BITS-1:0] wid, input logic [NR_BITS-1:0] rs1,
                       input logic [NR_BITS-1:0] rs2, input logic [NR_BITS-1:0] rs3,
                       input logic [NR_BITS-1:0] rd);
    chk_wid = wid;
    chk_rs1 = rs1;
    chk_rs2 = rs2;
    chk_rs3 = rs3;
    chk_rd  = rd;
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    rsv_valid   = 1'b0;
    rsv_wid     = '0;
    rsv_rd      = '0;
    rf_wr_ready = 1'b0;
    wb_if.valid = 1'b0;
    wb_if.wid   = '0;
    wb_if.pc    = '0;
    wb_if.tmask = '0;
    wb_if.rd    = '0;
    wb_if.data  = '0;
    wb_if.eop   = 1'b0;
    query('0, '0, '0, '0, '0);

    #1;
    check("rst_wb_ready", wb_if.ready, 0);
    check("rst_rf_wr_en", rf_wr_en, 0);
    check("rst_rel_valid", rel_valid, 0);
    check("rst_idle", idle, 1);

    step();
    reset = 1'b0;
    check("ready_before_edge", wb_if.ready, 0);
    step();
    check("ready_after_edge", wb_if.ready, 1);

    // Single beat with release of a reserved register.
    rf_wr_ready = 1'b1;
    reserve(1, 5);
    query(1, 5, 0, 0, 0);
    check("busy_after_rsv", chk_busy, 1);
    check("idle_after_rsv", idle, 0);
    drive_beat(1, 5, 4'b1011, D0, 1'b1);
    step();
    clear_beat();
    check("lat_wr_en", rf_wr_en, 4'b1011);
    check("lat_wr_wid", rf_wr_wid, 1);
    check("lat_wr_rd", rf_wr_rd, 5);
    check("lat_wr_data", rf_wr_data, D0);
    check("lat_no_rel_yet", rel_valid, 0);
    step();
    check("rel_valid", rel_valid, 1);
    check("rel_wid", rel_wid, 1);
    check("rel_rd", rel_rd, 5);
    check("drained_wr_en", rf_wr_en, 0);
    check("last_wb_5", last_wb_value[5], D0[31:0]);
    query(1, 5, 0, 0, 0);
    check("busy_after_rel", chk_busy, 0);
    step();
    check("rel_one_cycle", rel_valid, 0);
    check("idle_after_rel", idle, 1);

    // Write to x0: enables suppressed, beat still drains.
    drive_beat(0, 0, 4'b1111, D1, 1'b0);
    step();
    clear_beat();
    check("x0_wr_en", rf_wr_en, 0);
    check("x0_wr_rd", rf_wr_rd, 0);
    step();
    check("x0_drained_idle", idle, 1);
    check("x0_ready", wb_if.ready, 1);

    // Back-pressure: two beats fill the FIFO, third must wait.
    rf_wr_ready = 1'b0;
    drive_beat(0, 11, 4'b0001, DA, 1'b0);
    step();
    check("bp_ready_1", wb_if.ready, 1);
    drive_beat(1, 12, 4'b0010, DB, 1'b0);
    step();
    check("bp_ready_full", wb_if.ready, 0);
    drive_beat(2, 13, 4'b0100, DC, 1'b0);
    step();
    check("bp_ready_hold", wb_if.ready, 0);
    check("bp_head_a_rd", rf_wr_rd, 11);
    check("bp_head_a_en", rf_wr_en, 4'b0001);
    rf_wr_ready = 1'b1;
    step();
    check("bp_head_b_rd", rf_wr_rd, 12);
    check("bp_head_b_en", rf_wr_en, 4'b0010);
    check("bp_head_b_data", rf_wr_data, DB);
    check("bp_ready_reopen", wb_if.ready, 1);
    step();
    clear_beat();
    check("bp_head_c_rd", rf_wr_rd, 13);
    check("bp_head_c_wid", rf_wr_wid, 2);
    check("bp_head_c_en", rf_wr_en, 4'b0100);
    step();
    check("bp_drained_en", rf_wr_en, 0);
    check("bp_drained_idle", idle, 1);
    check("last_wb_11", last_wb_value[11], DA[31:0]);
    check("last_wb_12", last_wb_value[12], DB[31:0]);
    check("last_wb_13", last_wb_value[13], DC[31:0]);

    // Same-edge reserve and release of wid 2 rd 7: reservation survives.
    reserve(2, 7);
    drive_beat(2, 7, 4'b1111, D2, 1'b1);
    step();
    clear_beat();
    rsv_valid = 1'b1;
    rsv_wid   = 2;
    rsv_rd    = 7;
    step();
    rsv_valid = 1'b0;
    check("same_rel_valid", rel_valid, 1);
    check("same_rel_wid", rel_wid, 2);
    check("same_rel_rd", rel_rd, 7);
    query(2, 0, 0, 0, 7);
    check("same_busy", chk_busy, 1);
    check("same_not_idle", idle, 0);
    query(3, 0, 0, 0, 7);
    check("other_warp_free", chk_busy, 0);

    // Non-final beat releases nothing; final beat releases.
    reserve(0, 9);
    drive_beat(0, 9, 4'b0011, D3, 1'b0);
    step();
    clear_beat();
    step();
    check("eop0_no_rel", rel_valid, 0);
    query(0, 0, 9, 0, 0);
    check("eop0_busy", chk_busy, 1);
    drive_beat(0, 9, 4'b0011, D3, 1'b1);
    step();
    clear_beat();
    step();
    check("eop1_rel", rel_valid, 1);
    check("eop1_rel_rd", rel_rd, 9);
    check("eop1_rel_wid", rel_wid, 0);
    query(0, 0, 0, 9, 0);
    check("eop1_free", chk_busy, 0);

    // Reset with full FIFO and outstanding reservations.
    rf_wr_ready = 1'b0;
    reserve(0, 1);
    reserve(1, 2);
    reserve(3, 3);
    drive_beat(0, 20, 4'b1111, DA, 1'b1);
    step();
    drive_beat(1, 21, 4'b1111, DB, 1'b1);
    step();
    clear_beat();
    check("pre_rst_full", wb_if.ready, 0);
    check("pre_rst_busy_idle", idle, 0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", wb_if.ready, 0);
    check("mid_rst_wr_en", rf_wr_en, 0);
    check("mid_rst_idle", idle, 1);
    check("mid_rst_rel", rel_valid, 0);
    query(1, 2, 0, 0, 0);
    check("mid_rst_busy", chk_busy, 0);
    step();
    step();
    reset = 1'b0;
    check("post_rst_ready_low", wb_if.ready, 0);
    step();
    check("post_rst_ready", wb_if.ready, 1);
    check("post_rst_wr_en", rf_wr_en, 0);
    check("post_rst_rel", rel_valid, 0);
    check("post_rst_idle", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
